// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC micro-op sequencer: widths, instruction layout,
// opcode and ALU status encodings, FSM states.
package ecc_pkg;

  localparam int WID  = 256;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int TW   = 20;
  localparam logic [TW-1:0] TMO_DEF = 20'hFFFFF;

  // Low two opcode bits select the field op; [3:2] pass through to the ALU.
  localparam logic [1:0] OPC_FA  = 2'b00;
  localparam logic [1:0] OPC_MUL = 2'b01;
  localparam logic [1:0] OPC_INV = 2'b10;
  localparam logic [1:0] OPC_ILL = 2'b11;

  localparam logic [1:0] STAT_IDLE = 2'b00;

  // Packed so that field offsets match the 19-bit instruction word, MSB first.
  typedef struct packed {
    logic          swapop;
    logic          swapvl;
    logic [3:0]    opcode;
    logic          cin;
    logic [AW-1:0] dsta;
    logic [AW-1:0] dstb;
    logic [AW-1:0] srca;
    logic [AW-1:0] srcb;
  } ins_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

endpackage

// File: rtl/ecc_opseq_if.sv
// Sequencer-to-ALU bus: latched operands and control out, status/results back.
interface ecc_opseq_if;
  import ecc_pkg::*;

  logic [WID-1:0] alu_a;
  logic [WID-1:0] alu_b;
  logic           alu_c;
  logic           alu_en;
  logic           alu_swapop;
  logic           alu_swapvl;
  logic [3:0]     alu_opcode;
  logic [1:0]     alu_status;
  logic [WID-1:0] alu_r;
  logic [WID-1:0] alu_rswap;
  logic           alu_vld;

  modport master (
    output alu_a, alu_b, alu_c, alu_en, alu_swapop, alu_swapvl, alu_opcode,
    input  alu_status, alu_r, alu_rswap, alu_vld
  );

  modport slave (
    input  alu_a, alu_b, alu_c, alu_en, alu_swapop, alu_swapvl, alu_opcode,
    output alu_status, alu_r, alu_rswap, alu_vld
  );
endinterface

// File: rtl/ecc_regfile.sv
// Operand register file: host write port plus two write-back ports, three
// combinational read ports.
module ecc_regfile
  import ecc_pkg::*;
(
  input  logic           clk,
  input  logic           we_h_i,
  input  logic [AW-1:0]  addr_h_i,
  input  logic [WID-1:0] wd_h_i,
  input  logic           we_a_i,
  input  logic [AW-1:0]  addr_a_i,
  input  logic [WID-1:0] wd_a_i,
  input  logic           we_b_i,
  input  logic [AW-1:0]  addr_b_i,
  input  logic [WID-1:0] wd_b_i,
  input  logic [AW-1:0]  raddr_0_i,
  input  logic [AW-1:0]  raddr_1_i,
  input  logic [AW-1:0]  raddr_2_i,
  output logic [WID-1:0] rdata_0_o,
  output logic [WID-1:0] rdata_1_o,
  output logic [WID-1:0] rdata_2_o
);

  logic [WID-1:0] mem_q [NREG];

  // Later statements win: port B overrides port A when both target one entry.
  always_ff @(posedge clk) begin
    if (we_h_i) mem_q[addr_h_i] <= wd_h_i;
    if (we_a_i) mem_q[addr_a_i] <= wd_a_i;
    if (we_b_i) mem_q[addr_b_i] <= wd_b_i;
  end

  assign rdata_0_o = mem_q[raddr_0_i];
  assign rdata_1_o = mem_q[raddr_1_i];
  assign rdata_2_o = mem_q[raddr_2_i];

endmodule

// File: rtl/ecc_opseq.sv
// ECC micro-op sequencer: accepts one field instruction, issues it to the ALU,
// waits for the result (with timeout) and writes it back to the register file.
module ecc_opseq
  import ecc_pkg::*;
#(
  parameter logic [TW-1:0] TMO = TMO_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_vld_i,
  output logic                ins_rdy_o,
  input  logic [18:0]         ins_i,
  input  logic                host_we_i,
  input  logic [AW-1:0]       host_addr_i,
  input  logic [WID-1:0]      host_wd_i,
  output logic [WID-1:0]      host_rd_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          err_o,
  ecc_opseq_if.master         alu
);

  state_t         state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [1:0]     err_q, err_d;
  ins_t           ins_w;
  logic [WID-1:0] a_q, b_q, rd_a_w, rd_b_w;
  logic           c_q, swapop_q, swapvl_q;
  logic [3:0]     opcode_q;
  logic [AW-1:0]  dsta_q, dstb_q;
  logic           ld_ops, wb_a, wb_b, rdy_c, en_c, done_c;

  assign ins_w = ins_t'(ins_i);

  ecc_regfile u_rf (
    .clk       (clk),
    .we_h_i    (host_we_i && (state_q == ST_IDLE)),
    .addr_h_i  (host_addr_i),
    .wd_h_i    (host_wd_i),
    .we_a_i    (wb_a),
    .addr_a_i  (dsta_q),
    .wd_a_i    (alu.alu_r),
    .we_b_i    (wb_b),
    .addr_b_i  (dstb_q),
    .wd_b_i    (alu.alu_rswap),
    .raddr_0_i (ins_w.srca),
    .raddr_1_i (ins_w.srcb),
    .raddr_2_i (host_addr_i),
    .rdata_0_o (rd_a_w),
    .rdata_1_o (rd_b_w),
    .rdata_2_o (host_rd_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_ops  = 1'b0;
    wb_a    = 1'b0;
    wb_b    = 1'b0;
    rdy_c   = 1'b0;
    en_c    = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_c = !host_we_i;
        if (ins_vld_i && rdy_c) begin
          if (!ins_w.swapop && (ins_w.opcode[1:0] == OPC_ILL)) begin
            err_d[0] = 1'b1;
          end else begin
            ld_ops  = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      // Holding here also absorbs the ALU's return-to-idle after a previous op.
      ST_ISSUE: begin
        if (alu.alu_status == STAT_IDLE) begin
          en_c    = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (alu.alu_vld) begin
          wb_a    = 1'b1;
          wb_b    = swapop_q;
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == TMO - 1'b1) begin
          err_d[1] = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      swapop_q <= 1'b0;
      swapvl_q <= 1'b0;
      opcode_q <= '0;
      dsta_q   <= '0;
      dstb_q   <= '0;
    end else if (ld_ops) begin
      a_q      <= rd_a_w;
      b_q      <= rd_b_w;
      c_q      <= ins_w.cin;
      swapop_q <= ins_w.swapop;
      swapvl_q <= ins_w.swapvl;
      opcode_q <= ins_w.opcode;
      dsta_q   <= ins_w.dsta;
      dstb_q   <= ins_w.dstb;
    end
  end

  assign ins_rdy_o      = rdy_c;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_c;
  assign err_o          = err_q;
  assign alu.alu_a      = a_q;
  assign alu.alu_b      = b_q;
  assign alu.alu_c      = c_q;
  assign alu.alu_en     = en_c;
  assign alu.alu_swapop = swapop_q;
  assign alu.alu_swapvl = swapvl_q;
  assign alu.alu_opcode = opcode_q;

endmodule

// File: tb/tb_ecc_opseq.sv
// Directed bench for ecc_opseq with a behavioural ALU stub (programmable latency / hang).
module tb_ecc_opseq;
  import ecc_pkg::*;

  localparam logic [TW-1:0] TB_TMO = 20'd1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ins_vld = 1'b0;
  logic           ins_rdy;
  ins_t           ins = '0;
  logic           host_we = 1'b0;
  logic [AW-1:0]  host_addr = '0;
  logic [WID-1:0] host_wd = '0;
  logic [WID-1:0] host_rd;
  logic           busy, done;
  logic [1:0]     err;

  int n_vec = 0;
  int n_err = 0;
  int stub_delay = 2;
  bit stub_hang = 1'b0;
  int stub_cnt = 0;
  bit stub_busy = 1'b0;

  ecc_opseq_if alu_if ();

  ecc_opseq #(.TMO(TB_TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ins_vld_i   (ins_vld),
    .ins_rdy_o   (ins_rdy),
    .ins_i       (ins),
    .host_we_i   (host_we),
    .host_addr_i (host_addr),
    .host_wd_i   (host_wd),
    .host_rd_o   (host_rd),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .alu         (alu_if.master)
  );

  always #5 clk = ~clk;

  // ALU stub: FA = a+b+c, MUL = a*b, CSWAP swaps when swapvl; vld held one cycle.
  always @(posedge clk) begin
    if (rst) begin
      stub_busy         <= 1'b0;
      stub_cnt          <= 0;
      alu_if.alu_vld    <= 1'b0;
      alu_if.alu_status <= 2'b00;
      alu_if.alu_r      <= '0;
      alu_if.alu_rswap  <= '0;
    end else if (alu_if.alu_vld) begin
      alu_if.alu_vld    <= 1'b0;
      alu_if.alu_status <= 2'b00;
      stub_busy         <= 1'b0;
    end else if (alu_if.alu_en) begin
      stub_busy         <= 1'b1;
      alu_if.alu_status <= 2'b01;
      stub_cnt          <= stub_delay;
      if (alu_if.alu_swapop) begin
        alu_if.alu_r     <= alu_if.alu_swapvl ? alu_if.alu_b : alu_if.alu_a;
        alu_if.alu_rswap <= alu_if.alu_swapvl ? alu_if.alu_a : alu_if.alu_b;
      end else if (alu_if.alu_opcode[1:0] == 2'b01) begin
        alu_if.alu_r     <= alu_if.alu_a * alu_if.alu_b;
        alu_if.alu_rswap <= '0;
      end else begin
        alu_if.alu_r     <= alu_if.alu_a + alu_if.alu_b + {255'd0, alu_if.alu_c};
        alu_if.alu_rswap <= '0;
      end
    end else if (stub_busy && !stub_hang) begin
      if (stub_cnt <= 1) alu_if.alu_vld <= 1'b1;
      else stub_cnt <= stub_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic sop, input logic svl, input logic [3:0] op,
                              input logic cin, input logic [2:0] da, input logic [2:0] db,
                              input logic [2:0] sa, input logic [2:0] sb);
    ins_t x;
    x.swapop = sop; x.swapvl = svl; x.opcode = op; x.cin = cin;
    x.dsta = da; x.dstb = db; x.srca = sa; x.srcb = sb;
    return x;
  endfunction

  task automatic host_wr(input logic [AW-1:0] a, input logic [WID-1:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wd = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [WID-1:0] exp);
    host_addr = a;
    #1;
    chk(tag, host_rd, exp);
  endtask

  // Present one instruction, then track alu_en/done pulses until busy drops.
  task automatic run_op(input ins_t x, input int bound, output int n_en, output int n_done,
                        output int cyc, output bit expired);
    n_en = 0; n_done = 0; cyc = 0; expired = 1'b1;
    @(negedge clk);
    ins_vld = 1'b1; ins = x;
    @(negedge clk);
    ins_vld = 1'b0;
    for (int k = 0; k < bound; k++) begin
      #1;
      if (alu_if.alu_en) n_en++;
      if (done) n_done++;
      if (!busy) begin
        expired = 1'b0;
        cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int  n_en, n_done, cyc;
    bit  expired;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", ins_rdy, 1);
    chk("rst_err", err, 0);
    chk("rst_alu_en", alu_if.alu_en, 0);
    chk("rst_alu_a", alu_if.alu_a, 0);
    chk("rst_alu_opcode", alu_if.alu_opcode, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_done", done, 0);

    // FA: 5 + 7 + 0 -> rf[3]
    host_wr(3'd1, 256'd5);
    host_wr(3'd2, 256'd7);
    rd_chk("host_rd1", 3'd1, 256'd5);
    stub_delay = 2;
    run_op(mk(0, 0, 4'b0000, 0, 3'd3, 3'd0, 3'd1, 3'd2), 100, n_en, n_done, cyc, expired);
    chk("fa_bound", expired, 0);
    chk("fa_en_count", n_en, 1);
    chk("fa_done_count", n_done, 1);
    chk("fa_alu_a_held", alu_if.alu_a, 256'd5);
    chk("fa_alu_b_held", alu_if.alu_b, 256'd7);
    rd_chk("fa_rf3", 3'd3, 256'd12);

    // MUL 2 * 3 with a 300-cycle ALU
    host_wr(3'd5, 256'd2);
    host_wr(3'd6, 256'd3);
    stub_delay = 300;
    run_op(mk(0, 0, 4'b0001, 0, 3'd4, 3'd0, 3'd5, 3'd6), 400, n_en, n_done, cyc, expired);
    chk("mul_bound", expired, 0);
    chk("mul_en_count", n_en, 1);
    chk("mul_done_count", n_done, 1);
    chk("mul_latency_ge300", (cyc >= 300), 1);
    rd_chk("mul_rf4", 3'd4, 256'd6);

    // CSWAP swapvl=1 then swapvl=0
    stub_delay = 1;
    host_wr(3'd0, 256'd9);
    host_wr(3'd1, 256'd4);
    run_op(mk(1, 1, 4'b0000, 0, 3'd0, 3'd1, 3'd0, 3'd1), 100, n_en, n_done, cyc, expired);
    chk("swap1_bound", expired, 0);
    rd_chk("swap1_rf0", 3'd0, 256'd4);
    rd_chk("swap1_rf1", 3'd1, 256'd9);
    run_op(mk(1, 0, 4'b0000, 0, 3'd0, 3'd1, 3'd0, 3'd1), 100, n_en, n_done, cyc, expired);
    chk("swap0_bound", expired, 0);
    rd_chk("swap0_rf0", 3'd0, 256'd4);
    rd_chk("swap0_rf1", 3'd1, 256'd9);
    // dsta == dstb: the swapped-B result (rf[1]=9) must land
    run_op(mk(1, 0, 4'b0000, 0, 3'd7, 3'd7, 3'd0, 3'd1), 100, n_en, n_done, cyc, expired);
    chk("samedst_done", n_done, 1);
    rd_chk("samedst_rf7", 3'd7, 256'd9);

    // Illegal opcode: no issue, no write, err[0]
    run_op(mk(0, 0, 4'b0011, 1, 3'd3, 3'd0, 3'd1, 3'd2), 10, n_en, n_done, cyc, expired);
    chk("ill_bound", expired, 0);
    chk("ill_en_count", n_en, 0);
    chk("ill_err", err, 2'b01);
    chk("ill_rdy", ins_rdy, 1);
    rd_chk("ill_rf3", 3'd3, 256'd12);

    // Hung ALU: timeout after TB_TMO cycles, err[0] stays sticky
    stub_hang = 1'b1;
    run_op(mk(0, 0, 4'b0000, 0, 3'd5, 3'd0, 3'd1, 3'd2), 1100, n_en, n_done, cyc, expired);
    chk("tmo_bound", expired, 0);
    chk("tmo_err", err, 2'b11);
    chk("tmo_no_done", n_done, 0);
    chk("tmo_latency_ge1000", (cyc >= 1000), 1);
    rd_chk("tmo_rf5", 3'd5, 256'd2);
    // Host resets the stub through its own state; sequencer continues
    @(negedge clk);
    stub_hang = 1'b0;
    stub_busy = 1'b0;
    alu_if.alu_status = 2'b00;
    run_op(mk(0, 0, 4'b0000, 1, 3'd2, 3'd0, 3'd5, 3'd6), 100, n_en, n_done, cyc, expired);
    chk("post_tmo_bound", expired, 0);
    chk("post_tmo_done", n_done, 1);
    rd_chk("post_tmo_rf2", 3'd2, 256'd6);

    // rst in WAIT discards the op and clears err
    stub_delay = 50;
    @(negedge clk);
    ins_vld = 1'b1; ins = mk(0, 0, 4'b0000, 0, 3'd3, 3'd0, 3'd5, 3'd6);
    @(negedge clk);
    ins_vld = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("wait_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    repeat (60) @(negedge clk);
    #1;
    chk("midrst_no_done", done, 0);
    rd_chk("midrst_rf3", 3'd3, 256'd12);

    // Host write wins over a pending instruction in the same cycle
    @(negedge clk);
    host_we = 1'b1; host_addr = 3'd2; host_wd = 256'd1;
    ins_vld = 1'b1; ins = mk(0, 0, 4'b0000, 0, 3'd3, 3'd0, 3'd1, 3'd2);
    #1;
    chk("hostwe_rdy", ins_rdy, 0);
    @(negedge clk);
    host_we = 1'b0;
    ins_vld = 1'b0;
    #1;
    chk("hostwe_not_accepted", busy, 0);
    rd_chk("hostwe_rf2", 3'd2, 256'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
